complex_acc: RTL and testbench
==============================

Name: complex_acc

Overview:
- Downstream consumer of the packed complex multiplier output: takes a stream of 16-bit complex products {real[15:8], imag[7:0]} and accumulates LEN consecutive samples per component.
- Emits one packed complex sum per frame, with a sticky overflow flag.
- Intended use: dot-product / correlator / DFT-bin accumulation following the multiplier stage.
- Valid/ready handshake on input and output; in_ready deasserts while a result is held unaccepted.

Parameters:
- N, 16, packed input width; real = din[N-1:N/2], imag = din[N/2-1:0].
- ACC_W, 16, per-component accumulator and output width; must be at least N/2.
- LEN, 8, samples per frame; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous frame abort: clears accumulators, counter and the sticky flag; the output register is untouched.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept din this cycle.
- din  input  N  packed complex sample {re, im}, each component N/2-bit signed two's complement.
- out_valid  output  1  out_data / out_ovf hold a completed frame sum.
- out_ready  input  1  downstream accepts the result.
- out_data  output  2*ACC_W  {sum_re[ACC_W-1:0], sum_im[ACC_W-1:0]}.
- out_ovf  output  1  signed overflow occurred in either component during the frame.

Behaviour:
- Reset (rst=1 at clk edge):
  - acc_re, acc_im, cnt and ovf_sticky = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - rst has priority over clr and every other input. in_ready = 1 on the cycle after reset.
- Combinational in_ready = !out_valid || out_ready. Sample accepted when in_valid && in_ready.
- Each component is sign-extended from N/2 to ACC_W bits. Addition wraps modulo 2^ACC_W.
- Overflow per add: operands have the same sign and the result sign differs. Either component overflowing sets ovf_sticky.
- Counter cnt runs 0..LEN-1 and counts accepted samples in the current frame.
- Accept with cnt < LEN-1:
  - acc_* <= acc_* + sample.
  - cnt <= cnt+1.
  - ovf_sticky |= overflow of this add.
- Accept with cnt == LEN-1 (final sample):
  - out_data <= {acc_re+s_re, acc_im+s_im}.
  - out_ovf <= ovf_sticky | overflow of this add.
  - out_valid <= 1. Latency is 1 cycle from the final accept to out_valid.
  - acc_*, cnt and ovf_sticky <= 0.
- Output handshake: out_valid && out_ready clears out_valid next cycle, unless a new final sample is accepted in the same cycle, in which case out_valid stays 1 with the new data. out_data is held stable while out_valid && !out_ready.
- Same-cycle output handshake and input accept: both take effect; a sample accepted that cycle enters the new frame normally. No bubble is required.
- No-input cycles: in_valid=0 leaves all state unchanged. Frames span any number of gap cycles.
- clr while accepting a sample:
  - clr wins; the sample is discarded.
  - acc, cnt and ovf_sticky = 0.
  - out_valid / out_data are unaffected, so a pending result is still delivered.
- Reset mid-frame or with a result pending: the partial frame and the pending result are both lost; nothing is emitted.
- Structure: two-state control, ACCUM and HOLD (out_valid=1); HOLD returns to ACCUM on output handshake without a new final sample.

Test Plan:
- LEN=4, ACC_W=16. din=0x0102 for 4 consecutive cycles, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_data=0x0004_0008, out_ovf=0.
- Negative values: din=0xFF80 (re=-1, im=-128) x4 -> out_data=0xFFFC_FE00, out_ovf=0.
- Backpressure:
  - Complete a frame with out_ready=0 for 5 cycles -> out_data stable, in_ready=0, in_valid samples ignored.
  - Raise out_ready -> in_ready=1 the same cycle; a sample accepted then starts the next frame.
  - 8 back-to-back frames with out_ready=1 -> 8 results with no lost samples.
- Overflow, ACC_W=10, LEN=8: din=0x7F7F x8 -> out_data={0x3F8,0x3F8} (1016 wrapped to -8), out_ovf=1. The next frame of 0x0101 x8 -> {0x008,0x008}, out_ovf=0 (sticky cleared).
- Abort, LEN=4:
  - clr after 2 accepted samples, then 0x0203 x4 -> out_data=0x0008_000C.
  - clr asserted while out_valid=1 -> result still delivered unchanged.
- Reset mid-frame:
  - Reset after 3 of 4 samples -> out_valid=0, out_data=0.
  - Then 0x0101 x4 -> 0x0004_0004. There must be no early result from the stale count.

Source files
------------

// File: rtl/complex_acc.sv
// Frame accumulator for packed complex samples {re, im}: sums LEN accepted samples per
// component and presents one packed sum per frame with a sticky signed-overflow flag.
module complex_acc #(
    parameter int N     = 16,
    parameter int ACC_W = 16,
    parameter int LEN   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [N-1:0]         i_din,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*ACC_W-1:0]   o_out_data,
    output logic                 o_out_ovf
);

    localparam int H     = N / 2;
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {S_ACCUM, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ACC_W-1:0]    r_acc_re;
    logic [ACC_W-1:0]    r_acc_im;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [2*ACC_W-1:0]  r_out_data;
    logic                r_out_ovf;

    logic signed [H-1:0] w_re_in;
    logic signed [H-1:0] w_im_in;
    logic [ACC_W-1:0]    w_s_re;
    logic [ACC_W-1:0]    w_s_im;
    logic [ACC_W-1:0]    w_sum_re;
    logic [ACC_W-1:0]    w_sum_im;
    logic                w_ovf_re;
    logic                w_ovf_im;
    logic                w_ovf_add;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_last;

    assign w_re_in = i_din[N-1:H];
    assign w_im_in = i_din[H-1:0];

    // Sizing casts of signed operands sign-extend each component to the accumulator width.
    assign w_s_re = ACC_W'(w_re_in);
    assign w_s_im = ACC_W'(w_im_in);

    assign w_sum_re = r_acc_re + w_s_re;
    assign w_sum_im = r_acc_im + w_s_im;

    assign w_ovf_re  = (r_acc_re[ACC_W-1] == w_s_re[ACC_W-1]) &&
                       (w_sum_re[ACC_W-1] != r_acc_re[ACC_W-1]);
    assign w_ovf_im  = (r_acc_im[ACC_W-1] == w_s_im[ACC_W-1]) &&
                       (w_sum_im[ACC_W-1] != r_acc_im[ACC_W-1]);
    assign w_ovf_add = w_ovf_re | w_ovf_im;

    // A held result only blocks input until the consumer takes it in the same cycle.
    assign w_in_ready = (r_state == S_ACCUM) || i_out_ready;
    // Abort beats a concurrent sample, so a cleared cycle never counts as an accept.
    assign w_accept   = i_in_valid && w_in_ready && !i_clr;
    assign w_last     = w_accept && (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_ACCUM: if (w_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (i_out_ready && !w_last) w_state_nxt = S_ACCUM;
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_ACCUM;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_clr) begin
                r_acc_re <= '0;
                r_acc_im <= '0;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc_re   <= '0;
                    r_acc_im   <= '0;
                    r_cnt      <= '0;
                    r_ovf      <= 1'b0;
                    r_out_data <= {w_sum_re, w_sum_im};
                    r_out_ovf  <= r_ovf | w_ovf_add;
                end else begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    r_cnt    <= r_cnt + 1'b1;
                    r_ovf    <= r_ovf | w_ovf_add;
                end
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == S_HOLD);
    assign o_out_data  = r_out_data;
    assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_complex_acc.sv
// Bench for complex_acc: two instances (LEN=4/ACC_W=16 and LEN=8/ACC_W=10) checked every
// cycle against an integer frame model, plus literal expectations for directed frames.
module tb_complex_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2];
    logic        clr[2];
    logic        iv[2];
    logic        ordy[2];
    logic [15:0] din[2];

    logic        irdy_a, irdy_b, ov_a, ov_b, oo_a, oo_b;
    logic [31:0] od_a;
    logic [19:0] od_b;

    complex_acc #(.N(16), .ACC_W(16), .LEN(4)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_clr(clr[0]), .i_in_valid(iv[0]),
        .o_in_ready(irdy_a), .i_din(din[0]), .o_out_valid(ov_a),
        .i_out_ready(ordy[0]), .o_out_data(od_a), .o_out_ovf(oo_a));

    complex_acc #(.N(16), .ACC_W(10), .LEN(8)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_clr(clr[1]), .i_in_valid(iv[1]),
        .o_in_ready(irdy_b), .i_din(din[1]), .o_out_valid(ov_b),
        .i_out_ready(ordy[1]), .o_out_data(od_b), .o_out_ovf(oo_b));

    int checks = 0;
    int errors = 0;
    int res_a  = 0;
    bit started = 0;

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Frame model: integer running sums, each add checked against the signed range.
    int          lenp[2] = '{4, 8};
    int          awp[2]  = '{16, 10};
    int          m_cnt[2], m_re[2], m_im[2];
    bit          m_ovf[2], m_ov[2], m_oo[2];
    logic [31:0] m_od[2];

    function automatic int wrapv(input int v, input int w);
        int m = 1 << w;
        int r = ((v % m) + m) % m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic bit out_of_range(input int v, input int w);
        return (v > (1 << (w - 1)) - 1) || (v < -(1 << (w - 1)));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                m_cnt[i] = 0; m_re[i] = 0; m_im[i] = 0; m_ovf[i] = 0;
                m_ov[i] = 0; m_oo[i] = 0; m_od[i] = '0;
            end else begin
                bit take;
                int xr, xi, sr, si, mask;
                take = iv[i] && (!m_ov[i] || ordy[i]);
                if (m_ov[i] && ordy[i]) m_ov[i] = 0;
                if (clr[i]) begin
                    m_cnt[i] = 0; m_re[i] = 0; m_im[i] = 0; m_ovf[i] = 0;
                end else if (take) begin
                    xr = int'($signed(din[i][15:8]));
                    xi = int'($signed(din[i][7:0]));
                    sr = m_re[i] + xr;
                    si = m_im[i] + xi;
                    if (out_of_range(sr, awp[i]) || out_of_range(si, awp[i])) m_ovf[i] = 1;
                    m_re[i] = wrapv(sr, awp[i]);
                    m_im[i] = wrapv(si, awp[i]);
                    m_cnt[i]++;
                    if (m_cnt[i] == lenp[i]) begin
                        mask    = (awp[i] == 16) ? 32'hFFFF : ((1 << awp[i]) - 1);
                        m_od[i] = 32'(((m_re[i] & mask) << awp[i]) | (m_im[i] & mask));
                        m_oo[i] = m_ovf[i];
                        m_ov[i] = 1;
                        m_cnt[i] = 0; m_re[i] = 0; m_im[i] = 0; m_ovf[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("a_valid", ov_a, m_ov[0]);
            check("a_ready", irdy_a, !m_ov[0] || ordy[0]);
            check("a_data",  od_a, m_od[0]);
            check("a_ovf",   oo_a, m_oo[0]);
            check("b_valid", ov_b, m_ov[1]);
            check("b_ready", irdy_b, !m_ov[1] || ordy[1]);
            check("b_data",  od_b, m_od[1]);
            check("b_ovf",   oo_b, m_oo[1]);
            if (ov_a && ordy[0]) res_a++;
        end
    end

    function automatic logic get_v(input int i);
        return (i == 0) ? ov_a : ov_b;
    endfunction
    function automatic logic get_r(input int i);
        return (i == 0) ? irdy_a : irdy_b;
    endfunction
    function automatic logic get_o(input int i);
        return (i == 0) ? oo_a : oo_b;
    endfunction
    function automatic longint get_d(input int i);
        return (i == 0) ? longint'(od_a) : longint'(od_b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int i, input logic [15:0] d, input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            iv[i] = 1'b1;
            din[i] = d;
            #1;
            while (!get_r(i) && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed %0d, wanted 1", get_r(i));
            end
            step();
        end
        iv[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; clr[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0;
        end
        step();
        started = 1;
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        check("rst_valid", ov_a, 0);
        check("rst_data",  od_a, 0);
        check("rst_ovf",   oo_a, 0);
        check("rst_ready", irdy_a, 1);

        // Basic frame and 1-cycle latency
        send_n(0, 16'h0102, 4);
        check("basic_valid", get_v(0), 1);
        check("basic_data",  get_d(0), 64'h0004_0008);
        check("basic_ovf",   get_o(0), 0);
        step();

        // Negative components
        send_n(0, 16'hFF80, 4);
        check("neg_data", get_d(0), 64'hFFFC_FE00);
        check("neg_ovf",  get_o(0), 0);
        step();

        // Backpressure: result held, input blocked
        ordy[0] = 1'b0;
        send_n(0, 16'h0102, 4);
        iv[0] = 1'b1;
        din[0] = 16'h7777;
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", get_r(0), 0);
            check("bp_data",  get_d(0), 64'h0004_0008);
            step();
        end
        ordy[0] = 1'b1;
        din[0] = 16'h0001;
        #1;
        check("bp_release_ready", get_r(0), 1);
        step();
        iv[0] = 1'b0;
        check("bp_consumed", get_v(0), 0);
        send_n(0, 16'h0001, 3);
        check("bp_next_data", get_d(0), 64'h0000_0004);
        step();

        // 8 back-to-back frames
        res_a = 0;
        send_n(0, 16'h0101, 32);
        step();
        check("b2b_results", res_a, 8);

        // Abort with a concurrent sample
        send_n(0, 16'h1111, 2);
        clr[0] = 1'b1;
        iv[0] = 1'b1;
        din[0] = 16'h7777;
        step();
        clr[0] = 1'b0;
        iv[0] = 1'b0;
        send_n(0, 16'h0203, 4);
        check("abort_data", get_d(0), 64'h0008_000C);
        step();

        // Abort while a result is pending
        ordy[0] = 1'b0;
        send_n(0, 16'h0102, 4);
        clr[0] = 1'b1;
        iv[0] = 1'b1;
        din[0] = 16'h5555;
        step();
        clr[0] = 1'b0;
        iv[0] = 1'b0;
        check("clr_hold_valid", get_v(0), 1);
        check("clr_hold_data",  get_d(0), 64'h0004_0008);
        ordy[0] = 1'b1;
        step();
        check("clr_hold_done", get_v(0), 0);

        // Reset with a pending result, then mid-frame
        ordy[0] = 1'b0;
        send_n(0, 16'h0102, 4);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        ordy[0] = 1'b1;
        check("rst_pend_valid", get_v(0), 0);
        check("rst_pend_data",  get_d(0), 0);
        send_n(0, 16'h0303, 3);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("rst_mid_valid", get_v(0), 0);
        check("rst_mid_data",  get_d(0), 0);
        send_n(0, 16'h0101, 1);
        check("rst_no_early", get_v(0), 0);
        send_n(0, 16'h0101, 3);
        check("rst_after_valid", get_v(0), 1);
        check("rst_after_data",  get_d(0), 64'h0004_0004);
        step();

        // Overflow on the narrow instance, then sticky cleared
        send_n(1, 16'h7F7F, 8);
        check("ovf_valid", get_v(1), 1);
        check("ovf_data",  get_d(1), 64'hFE3F8);
        check("ovf_flag",  get_o(1), 1);
        step();
        send_n(1, 16'h0101, 8);
        check("ovf_clear_data", get_d(1), 64'h02008);
        check("ovf_clear_flag", get_o(1), 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
